// File: rtl/sad_window_accumulator_pkg.sv
// Shared depth-map pipeline constants and width helpers for the SAD and
// winner-take-all stages.
package sad_window_accumulator_pkg;

    localparam int unsigned window_size_default = 5;
    localparam int unsigned num_bits_default    = 8;

    // Widest column sum: window_size lanes of all-ones.
    function automatic int unsigned col_width(int unsigned ws, int unsigned nb);
        return nb + int'($clog2(ws));
    endfunction

    // Widest window sum: window_size^2 lanes of all-ones.
    function automatic int unsigned sad_width(int unsigned ws, int unsigned nb);
        return nb + int'($clog2(ws * ws));
    endfunction

endpackage

// File: rtl/sad_window_accumulator_if.sv
// Column stream in, SAD stream out, between the absolute-difference stage
// and the winner-take-all selector.
interface sad_window_accumulator_if
    import sad_window_accumulator_pkg::*;
#(
    parameter int unsigned window_size = window_size_default,
    parameter int unsigned num_bits    = num_bits_default,
    parameter int unsigned sad_bits    = sad_width(window_size, num_bits)
);

    logic                            in_valid;
    logic                            line_start;
    logic [num_bits*window_size-1:0] abs_diff;
    logic [sad_bits-1:0]             sad_out;
    logic                            sad_valid;

    modport master (
        output in_valid, line_start, abs_diff,
        input  sad_out, sad_valid
    );

    modport slave (
        input  in_valid, line_start, abs_diff,
        output sad_out, sad_valid
    );

endinterface

// File: rtl/sad_window_accumulator_column_sum.sv
// Stage 1: registered sum of one window column, with valid and line_start
// carried alongside.
module sad_window_accumulator_column_sum
    import sad_window_accumulator_pkg::*;
#(
    parameter int unsigned window_size = window_size_default,
    parameter int unsigned num_bits    = num_bits_default,
    parameter int unsigned col_bits    = col_width(window_size, num_bits)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            in_valid,
    input  logic                            line_start,
    input  logic [num_bits*window_size-1:0] abs_diff,
    output logic [col_bits-1:0]             col_sum,
    output logic                            col_valid,
    output logic                            col_line_start
);

    logic [col_bits-1:0] lane_total;

    always_comb begin
        lane_total = '0;
        for (int unsigned i = 0; i < window_size; i++) begin
            lane_total = lane_total + col_bits'(abs_diff[num_bits*i +: num_bits]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            col_sum        <= '0;
            col_valid      <= 1'b0;
            col_line_start <= 1'b0;
        end else begin
            col_valid <= in_valid;
            if (in_valid) begin
                col_sum        <= lane_total;
                col_line_start <= line_start;
            end
        end
    end

endmodule

// File: rtl/sad_window_accumulator.sv
// Sliding-window SAD: sums each incoming column, then keeps a running sum
// over the last window_size columns of the current image line.
module sad_window_accumulator
    import sad_window_accumulator_pkg::*;
#(
    parameter int unsigned window_size = window_size_default,
    parameter int unsigned num_bits    = num_bits_default,
    parameter int unsigned col_bits    = col_width(window_size, num_bits),
    parameter int unsigned sad_bits    = sad_width(window_size, num_bits)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    sad_window_accumulator_if.slave  bus
);

    localparam int unsigned fill_bits = $clog2(window_size + 1);

    logic [col_bits-1:0]  col_sum;
    logic                 col_valid;
    logic                 col_line_start;

    logic [col_bits-1:0]  history [window_size];
    logic [col_bits-1:0]  oldest;
    logic [sad_bits-1:0]  run_sum;
    logic [sad_bits-1:0]  next_sum;
    logic [fill_bits-1:0] fill;
    logic [fill_bits-1:0] next_fill;
    logic                 valid_q;

    sad_window_accumulator_column_sum #(
        .window_size (window_size),
        .num_bits    (num_bits),
        .col_bits    (col_bits)
    ) u_column_sum (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (bus.in_valid),
        .line_start     (bus.line_start),
        .abs_diff       (bus.abs_diff),
        .col_sum        (col_sum),
        .col_valid      (col_valid),
        .col_line_start (col_line_start)
    );

    assign oldest = history[window_size-1];

    always_comb begin
        next_sum  = run_sum;
        next_fill = fill;
        if (col_line_start) begin
            next_sum  = sad_bits'(col_sum);
            next_fill = fill_bits'(1);
        end else begin
            // oldest is always part of run_sum, so this cannot underflow
            next_sum  = run_sum + sad_bits'(col_sum) - sad_bits'(oldest);
            next_fill = (fill == fill_bits'(window_size)) ? fill : fill + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            run_sum <= '0;
            fill    <= '0;
            valid_q <= 1'b0;
            for (int unsigned i = 0; i < window_size; i++) begin
                history[i] <= '0;
            end
        end else if (col_valid) begin
            run_sum    <= next_sum;
            fill       <= next_fill;
            valid_q    <= (next_fill == fill_bits'(window_size));
            history[0] <= col_sum;
            for (int unsigned i = 1; i < window_size; i++) begin
                history[i] <= col_line_start ? '0 : history[i-1];
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    // sad_out updates and holds exactly like the running sum, so share it
    assign bus.sad_out   = run_sum;
    assign bus.sad_valid = valid_q;

endmodule

// File: tb/tb_sad_window_accumulator.sv
// Bench for sad_window_accumulator: directed table, corner sequences and a
// randomized run against a queue-based window model.
module tb_sad_window_accumulator;

    localparam int WS = 5;
    localparam int NB = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sad_window_accumulator_if #(.window_size(WS), .num_bits(NB), .sad_bits(13)) bus ();

    sad_window_accumulator #(
        .window_size (WS),
        .num_bits    (NB),
        .col_bits    (11),
        .sad_bits    (13)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int lanes [WS];

    // Model: columns of the current line, pending stage-1 column, outputs.
    int cols [$];
    bit pv = 0;
    bit pls = 0;
    int pcol = 0;
    int m_sad = 0;
    bit m_valid = 0;

    typedef struct {
        bit v;
        bit ls;
        int lane;
        int exp_sad;
        bit exp_valid;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_lanes(input int v);
        for (int i = 0; i < WS; i++) lanes[i] = v;
    endtask

    task automatic model_edge(input bit v, input bit ls, input bit rstn, input int col);
        if (!rstn) begin
            pv = 0;
            m_sad = 0;
            m_valid = 0;
            cols.delete();
        end else begin
            if (pv) begin
                if (pls) cols.delete();
                cols.push_back(pcol);
                if (cols.size() > WS) void'(cols.pop_front());
                m_sad = 0;
                foreach (cols[j]) m_sad += cols[j];
                m_valid = (cols.size() == WS);
            end else begin
                m_valid = 0;
            end
            pv = v;
            if (v) begin
                pls = ls;
                pcol = col;
            end
        end
    endtask

    task automatic step(input bit v, input bit ls, input bit rstn);
        int col;
        col = 0;
        bus.in_valid = v;
        bus.line_start = ls;
        reset_n = rstn;
        for (int i = 0; i < WS; i++) begin
            bus.abs_diff[i*NB +: NB] = NB'(lanes[i]);
            col += lanes[i];
        end
        @(posedge clock);
        model_edge(v, ls, rstn, col);
        #1;
    endtask

    task automatic check_out(input string name, input int exp_sad, input bit exp_valid);
        check({name, "_sad"}, int'(bus.sad_out), exp_sad);
        check({name, "_valid"}, int'(bus.sad_valid), int'(exp_valid));
    endtask

    initial begin
        int got [$];
        int gap;
        int exp3 [3];
        bit v, ls, rstn;

        exp3[0] = 75; exp3[1] = 100; exp3[2] = 125;
        bus.in_valid = 0;
        bus.line_start = 0;
        bus.abs_diff = '0;
        set_lanes(0);

        // Case 1 (all ones) then case 2 (all 255); expectations two stages late.
        tbl[0]  = '{1, 1, 1,    0, 0};
        tbl[1]  = '{1, 0, 1,    5, 0};
        tbl[2]  = '{1, 0, 1,   10, 0};
        tbl[3]  = '{1, 0, 1,   15, 0};
        tbl[4]  = '{1, 0, 1,   20, 0};
        tbl[5]  = '{1, 0, 1,   25, 1};
        tbl[6]  = '{1, 0, 1,   25, 1};
        tbl[7]  = '{0, 0, 0,   25, 1};
        tbl[8]  = '{0, 0, 0,   25, 0};
        tbl[9]  = '{1, 1, 255,   25, 0};
        tbl[10] = '{1, 0, 255, 1275, 0};
        tbl[11] = '{1, 0, 255, 2550, 0};
        tbl[12] = '{1, 0, 255, 3825, 0};
        tbl[13] = '{1, 0, 255, 5100, 0};
        tbl[14] = '{1, 0, 255, 6375, 1};
        tbl[15] = '{0, 0, 0,   6375, 1};
        tbl[16] = '{0, 0, 0,   6375, 0};

        step(1, 0, 0);
        step(1, 1, 0);
        check_out("reset", 0, 0);

        for (int r = 0; r < 17; r++) begin
            set_lanes(tbl[r].lane);
            step(tbl[r].v, tbl[r].ls, 1);
            check_out($sformatf("tbl%0d", r), tbl[r].exp_sad, tbl[r].exp_valid);
        end

        // Cases 3/4: ramp columns, without and with idle gaps.
        for (int mode = 0; mode < 2; mode++) begin
            got.delete();
            for (int k = 1; k <= 7; k++) begin
                set_lanes(k);
                step(1, k == 1, 1);
                if (bus.sad_valid) got.push_back(int'(bus.sad_out));
                if (mode == 1) begin
                    gap = $urandom_range(1, 3);
                    for (int j = 0; j < gap; j++) begin
                        step(0, 0, 1);
                        if (bus.sad_valid) got.push_back(int'(bus.sad_out));
                    end
                end
            end
            for (int j = 0; j < 3; j++) begin
                step(0, 0, 1);
                if (bus.sad_valid) got.push_back(int'(bus.sad_out));
            end
            check($sformatf("ramp%0d_count", mode), got.size(), 3);
            for (int i = 0; i < 3; i++)
                check($sformatf("ramp%0d_sad%0d", mode, i), (got.size() > i) ? got[i] : -1, exp3[i]);
        end

        // Case 5: new line after a line of 9s leaves no residue.
        set_lanes(9);
        for (int k = 0; k < 7; k++) step(1, k == 0, 1);
        set_lanes(1);
        step(1, 1, 1);
        check_out("relinestart_old", 225, 1);
        for (int j = 1; j < 5; j++) begin
            step(1, 0, 1);
            check_out($sformatf("reline%0d", j), 5 * j, 0);
        end
        step(0, 0, 1);
        check_out("reline_full", 25, 1);
        step(0, 0, 1);
        check_out("reline_idle", 25, 0);

        // Consecutive line_start columns never complete a window.
        set_lanes(3);
        for (int k = 0; k < 6; k++) begin
            step(1, 1, 1);
            if (k > 0) check_out($sformatf("lsrun%0d", k), 15, 0);
        end
        step(1, 0, 0);
        step(0, 1, 1);
        check_out("ls_invalid", 0, 0);

        // Case 6: mid-line reset with in_valid high.
        set_lanes(7);
        for (int k = 0; k < 3; k++) step(1, k == 0, 1);
        step(1, 0, 0);
        check_out("midreset", 0, 0);
        set_lanes(2);
        for (int j = 0; j < 5; j++) begin
            step(1, 0, 1);
            check_out($sformatf("postreset%0d", j), 10 * j, 0);
        end
        step(0, 0, 1);
        check_out("postreset_full", 50, 1);

        // Randomized run against the model.
        for (int n = 0; n < 800; n++) begin
            rstn = ($urandom_range(0, 99) != 0);
            v = ($urandom_range(0, 9) < 7);
            ls = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) set_lanes(255);
            else for (int i = 0; i < WS; i++) lanes[i] = $urandom_range(0, 255);
            step(v, ls, rstn);
            check("rand_sad", int'(bus.sad_out), m_sad);
            check("rand_valid", int'(bus.sad_valid), int'(m_valid));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
